pipe_stage_buf: RTL
===================

# pipe_stage_buf

Parametrised elastic pipeline register replacing the fixed IF_ID/ID_EXE/EXE_MEM/MEM_WB register stages. It is a DEPTH-entry FIFO carrying a packed payload plus an exception vector (ExceptinPipeType layout, width EXC_W), with a valid/ready handshake on both sides. It also provides a synchronous flush. Once an excepting entry is accepted, it blocks all younger entries until that entry leaves the stage or a flush occurs.

## Interface
- DATA_W, 32, payload width (packed stage bundle), ≥1
- EXC_W, 9, exception vector width; nonzero vector = excepting entry
- DEPTH, 2, entries; power of two, 1..8
- CNT_W, $clog2(DEPTH+1), occupancy width (derived, not overridden)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream has an entry
- in_ready  out  1  stage accepts this cycle
- in_data  in  DATA_W  upstream payload
- in_exc  in  EXC_W  upstream exception vector
- out_valid  out  1  head entry present
- out_ready  in  1  downstream takes head this cycle
- out_data  out  DATA_W  head payload
- out_exc  out  EXC_W  head exception vector
- flush  in  1  discard all entries, synchronous
- hold  in  1  freeze output side (no pop), e.g. multicycle divide downstream
- count  out  CNT_W  current occupancy
- exc_block  out  1  an excepting entry is buffered; input closed

## Operation
- Storage: circular buffer, write pointer wp, read pointer rp, both log2(DEPTH) bits, wrapping modulo DEPTH. For DEPTH=1 the pointers are constant 0.
- push = in_valid & in_ready. pop = out_valid & out_ready & ~hold.
- in_ready = ~flush & ~exc_block & (count < DEPTH). Depends only on state, flush and hold-free terms, with no combinational path from out_ready. Full with a simultaneous pop therefore does not accept.
- out_valid = (count != 0). out_data/out_exc = entry[rp], combinational read of registered storage.
- On push: entry[wp] <= {in_data, in_exc}; wp++. If in_exc != 0, exc_block sets next cycle.
- On pop: rp++. If the popped entry's exc != 0, exc_block clears next cycle. Only one excepting entry can be buffered, so the popped one is it.
- count_next = count + push − pop. Push and pop in the same cycle leave count unchanged.
- flush has priority over everything. Next cycle count=0, wp=rp=0, exc_block=0, out_valid=0. Any push or pop in the flush cycle is void. Storage contents are not cleared.
- hold: pop suppressed. Push still allowed while count<DEPTH.
- Reset (rst=0, asynchronous): count=0, wp=rp=0, exc_block=0, all storage=0. Hence out_valid=0, out_data=0, out_exc=0, in_ready=1 immediately after reset release.

## Timing
- Latency 1: an entry pushed at edge N is on out_* after edge N (cycle N+1) when the stage was empty.
- Throughput 1 entry/cycle sustained for DEPTH≥2. For DEPTH=1, in_ready drops while full, so throughput is ≤1 per 2 cycles unless the entry is popped that cycle. Even then it is not re-accepted until the next cycle, because in_ready ignores out_ready.
- exc_block asserts the cycle after the excepting push, so in_ready is 0 from that cycle on. It deasserts the cycle after that entry pops or after a flush.
- flush asserted for one cycle empties the stage at the next edge. in_ready is 0 during the flush cycle itself.
- Asynchronous reset mid-operation drops all entries immediately, with no handshake completion. Deassertion is synchronised externally.

## Test plan
- Reset/idle: rst low then high → count=0, out_valid=0, out_data=0, in_ready=1, exc_block=0.
- Stream DEPTH=2: push 0x11,0x22,0x33 back-to-back, out_ready=1 → out_data 0x11,0x22,0x33 in cycles 1,2,3; count stays 1.
- Backpressure: out_ready=0, push 0xA,0xB,0xC → 0xA,0xB stored, count=2, in_ready=0, 0xC not accepted. Raise out_ready → 0xA popped; in_ready=1 the following cycle, 0xC accepted, order A,B,C preserved.
- Exception block: push 0x5 with in_exc=9'h008, then 0x6 (exc 0) → in_ready=0, exc_block=1, 0x6 held upstream. Pop 0x5 → exc_block=0 next cycle, 0x6 accepted.
- Flush with simultaneous push/pop: count=2, flush=1, in_valid=1, out_ready=1 → next cycle count=0, out_valid=0, exc_block=0. Next pushed 0x7 appears as out_data=0x7.
- hold and wrap: DEPTH=4, hold=1, push 4 entries → count=4. Release hold, push/pop continuously for 10 entries → wp/rp wrap, output order exact.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline stage: a DEPTH-entry FIFO of {payload, exception vector} with
// valid/ready on both sides, synchronous flush, output hold and exception blocking.
module pipe_stage_buf #(
  parameter  int DATA_W = 32,
  parameter  int EXC_W  = 9,
  parameter  int DEPTH  = 2,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [EXC_W-1:0]  in_exc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [EXC_W-1:0]  out_exc,
  input  logic              flush,
  input  logic              hold,
  output logic [CNT_W-1:0]  count,
  output logic              exc_block
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENT_W = DATA_W + EXC_W;

  logic [ENT_W-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wp_reg, wp_next;
  logic [PTR_W-1:0] rp_reg, rp_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             exc_block_reg, exc_block_next;
  logic             push, pop;
  logic [ENT_W-1:0] head;

  // in_ready deliberately ignores out_ready so no combinational path crosses the stage.
  assign in_ready  = ~flush & ~exc_block_reg & (count_reg < CNT_W'(DEPTH));
  assign out_valid = (count_reg != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready & ~hold & ~flush;

  assign head      = mem_reg[rp_reg];
  assign out_data  = head[ENT_W-1:EXC_W];
  assign out_exc   = head[EXC_W-1:0];
  assign count     = count_reg;
  assign exc_block = exc_block_reg;

  always_comb begin
    wp_next        = wp_reg;
    rp_next        = rp_reg;
    count_next     = count_reg;
    exc_block_next = exc_block_reg;
    if (flush) begin
      wp_next        = '0;
      rp_next        = '0;
      count_next     = '0;
      exc_block_next = 1'b0;
    end else begin
      // Only one excepting entry can be buffered, so popping any excepting head releases the block.
      if (pop) begin
        if (DEPTH > 1) rp_next = rp_reg + PTR_W'(1);
        if (|head[EXC_W-1:0]) exc_block_next = 1'b0;
      end
      if (push) begin
        if (DEPTH > 1) wp_next = wp_reg + PTR_W'(1);
        if (|in_exc) exc_block_next = 1'b1;
      end
      count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_reg        <= '0;
      rp_reg        <= '0;
      count_reg     <= '0;
      exc_block_reg <= 1'b0;
    end else begin
      wp_reg        <= wp_next;
      rp_reg        <= rp_next;
      count_reg     <= count_next;
      exc_block_reg <= exc_block_next;
    end
  end

  // Storage is left untouched by flush; only reset clears it.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        mem_reg[gi] <= '0;
      end else if (push && (wp_reg == PTR_W'(gi))) begin
        mem_reg[gi] <= {in_data, in_exc};
      end
    end
  end

endmodule
